// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative cache model.
// Trees are heap-ordered: node n has children 2n+1 (lower) and 2n+2 (upper).
package cache_pkg;

  localparam int MAX_W = 6;
  localparam int MAX_N = (1 << MAX_W) - 1;

  typedef logic [MAX_N-1:0] plru_bits_t;
  typedef logic [MAX_W-1:0] plru_way_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } plru_state_e;

  function automatic int way_w(int a);
    return $clog2(a);
  endfunction

  function automatic int set_w(int c, int d, int a);
    return c - d - $clog2(a);
  endfunction

  function automatic int node_n(int a);
    return a - 1;
  endfunction

  function automatic plru_way_t plru_victim(
    plru_bits_t bits,
    int         wb
  );
    plru_way_t way;
    int        node;
    way  = '0;
    node = 0;
    for (int l = 0; l < MAX_W; l++) begin
      if (l < wb) begin
        way  = {way[MAX_W-2:0], bits[node]};
        node = 2 * node + (bits[node] ? 2 : 1);
      end
    end
    return way;
  endfunction

  // Each node on the touched way's path is pointed at the other half.
  function automatic plru_bits_t plru_update(
    plru_bits_t bits,
    plru_way_t  way,
    int         wb
  );
    plru_bits_t nb;
    int         node;
    logic       b;
    nb   = bits;
    node = 0;
    for (int l = 0; l < MAX_W; l++) begin
      if (l < wb) begin
        b        = way[wb-1-l];
        nb[node] = ~b;
        node     = 2 * node + (b ? 2 : 1);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Victim selection and touch update for one set's PLRU tree.
module plru_tree_logic
  import cache_pkg::*;
#(
  parameter  int a_size = 4,
  localparam int W      = way_w(a_size),
  localparam int N      = node_n(a_size)
) (
  input  logic [N-1:0] bits_i,
  input  logic [W-1:0] touch_i,
  output logic [W-1:0] victim_o,
  output logic [N-1:0] upd_o
);

  always_comb begin
    victim_o = W'(plru_victim(plru_bits_t'(bits_i), W));
    upd_o    = N'(plru_update(plru_bits_t'(bits_i),
                              plru_way_t'(touch_i), W));
  end

endmodule

// File: rtl/plru_replacer.sv
// Per-set tree pseudo-LRU replacement unit with a 1-cycle pipeline,
// same-set write forwarding and a post-reset clearing walk.
module plru_replacer
  import cache_pkg::*;
#(
  parameter int c_size = 15,
  parameter int d_size = 6,
  parameter int a_size = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic [c_size-d_size-$clog2(a_size)-1:0] req_set,
  input  logic req_hit,
  input  logic [$clog2(a_size)-1:0] req_way,
  input  logic req_inv_valid,
  input  logic [$clog2(a_size)-1:0] req_inv_way,
  output logic ready,
  output logic rsp_valid,
  output logic [$clog2(a_size)-1:0] rsp_way,
  output logic rsp_evict
);

  localparam int S     = set_w(c_size, d_size, a_size);
  localparam int W     = way_w(a_size);
  localparam int N     = node_n(a_size);
  localparam int NSETS = 1 << S;

  plru_state_e state_q, state_d;
  logic [S-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d;
  logic hit_q, hit_d;
  logic inv_q, inv_d;
  logic [W-1:0] way_q, way_d;
  logic [W-1:0] inv_way_q, inv_way_d;
  logic [S-1:0] set_q, set_d;
  logic [N-1:0] bits_q, bits_d;

  logic [N-1:0] tree_q [NSETS];

  logic live;
  logic accept;
  logic [W-1:0] victim;
  logic [W-1:0] sel_way;
  logic [N-1:0] upd_bits;
  logic wr_en;
  logic [S-1:0] wr_idx;
  logic [N-1:0] wr_data;

  plru_tree_logic #(
    .a_size(a_size)
  ) u_tree (
    .bits_i  (bits_q),
    .touch_i (sel_way),
    .victim_o(victim),
    .upd_o   (upd_bits)
  );

  always_comb begin
    live      = vld_q & ~rst;
    ready     = (state_q == ST_RUN);
    accept    = req_valid & ready;
    sel_way   = hit_q ? way_q : (inv_q ? inv_way_q : victim);
    rsp_valid = live;
    rsp_way   = live ? sel_way : '0;
    rsp_evict = live & ~hit_q & ~inv_q;

    wr_en   = 1'b0;
    wr_idx  = set_q;
    wr_data = upd_bits;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = '0;
      end else if (live) begin
        wr_en = 1'b1;
      end
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + S'(1);
      if (cnt_q == S'(NSETS - 1)) state_d = ST_RUN;
    end

    vld_d     = accept;
    hit_d     = hit_q;
    inv_d     = inv_q;
    way_d     = way_q;
    inv_way_d = inv_way_q;
    set_d     = set_q;
    bits_d    = bits_q;
    if (accept) begin
      hit_d     = req_hit;
      inv_d     = req_inv_valid;
      way_d     = req_way;
      inv_way_d = req_inv_way;
      set_d     = req_set;
      // Bypass the tree written at this same edge.
      bits_d    = (live && set_q == req_set) ? upd_bits
                                             : tree_q[req_set];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      hit_q     <= 1'b0;
      inv_q     <= 1'b0;
      way_q     <= '0;
      inv_way_q <= '0;
      set_q     <= '0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      hit_q     <= hit_d;
      inv_q     <= inv_d;
      way_q     <= way_d;
      inv_way_q <= inv_way_d;
      set_q     <= set_d;
      bits_q    <= bits_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) tree_q[wr_idx] <= wr_data;
  end

endmodule
